// File: rtl/tree_node_loader.sv
// Byte-stream loader for the decision-tree node store: assembles 12-byte nodes,
// validates each one structurally and writes it to consecutive memory addresses.
module tree_node_loader #(
   parameter int TREE_DEPTH     = 512,
   parameter int NODE_WIDTH     = 95,
   parameter int ADDR_WIDTH     = 9,
   parameter int BYTES_PER_NODE = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  s_valid,
   input  logic [7:0]            s_data,
   input  logic                  s_last,
   output logic                  s_ready,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [NODE_WIDTH-1:0] wr_data,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [2:0]            err_code,
   output logic [ADDR_WIDTH:0]   node_count
);

   localparam int                IMG_BITS  = 8 * BYTES_PER_NODE;
   localparam logic [3:0]        LAST_BYTE = 4'(BYTES_PER_NODE - 1);
   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(TREE_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RECV,
      S_WRITE,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                      r_state;
   state_t                      w_nextState;
   logic [IMG_BITS-9:0]         r_asm;
   logic [3:0]                  r_byteCnt;
   logic                        r_lastBeat;
   logic                        r_wrEn;
   logic [ADDR_WIDTH-1:0]       r_wrAddr;
   logic [NODE_WIDTH-1:0]       r_wrData;
   logic [2:0]                  r_errCode;
   logic [ADDR_WIDTH:0]         r_nodeCount;

   logic                        w_accept;
   logic [IMG_BITS-1:0]         w_word;
   logic [ADDR_WIDTH-1:0]       w_addr;
   logic [ADDR_WIDTH-1:0]       w_id;
   logic [ADDR_WIDTH-1:0]       w_left;
   logic [ADDR_WIDTH-1:0]       w_right;
   logic                        w_isLeaf;
   logic                        w_halfLeaf;
   logic                        w_backRef;
   logic                        w_outOfRange;
   logic [2:0]                  w_chkCode;
   logic [2:0]                  w_newErr;
   logic                        w_doWrite;
   logic                        w_clear;

   // The final byte completes the word combinationally so it can be checked on its own edge.
   assign w_accept     = s_valid && s_ready;
   assign w_word       = {r_asm, s_data};
   assign w_addr       = r_nodeCount[ADDR_WIDTH-1:0];
   assign w_id         = w_word[94:86];
   assign w_left       = w_word[19:11];
   assign w_right      = w_word[10:2];
   assign w_isLeaf     = (w_left == '0) && (w_right == '0);
   assign w_halfLeaf   = (w_left == '0) != (w_right == '0);
   assign w_backRef    = !w_isLeaf && ((w_left <= w_addr) || (w_right <= w_addr));
   assign w_outOfRange = ({1'b0, w_left} >= DEPTH_W) || ({1'b0, w_right} >= DEPTH_W);

   always_comb begin
      w_chkCode = 3'b000;
      if (w_word[IMG_BITS-1])
         w_chkCode = 3'b011;
      else if (w_id != w_addr)
         w_chkCode = 3'b001;
      else if (w_halfLeaf || w_backRef || w_outOfRange)
         w_chkCode = 3'b010;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      w_newErr    = 3'b000;
      w_doWrite   = 1'b0;
      w_clear     = 1'b0;
      s_ready     = (r_state == S_RECV) || (r_state == S_DRAIN);
      busy        = (r_state == S_RECV) || (r_state == S_WRITE) || (r_state == S_DRAIN);
      done        = (r_state == S_DONE);
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_nextState = S_RECV;
               w_clear     = 1'b1;
            end
         end
         S_RECV: begin
            if (w_accept) begin
               if (r_nodeCount == DEPTH_W) begin
                  w_newErr    = 3'b101;
                  w_nextState = s_last ? S_DONE : S_DRAIN;
               end else if (r_byteCnt == LAST_BYTE) begin
                  if (w_chkCode != 3'b000) begin
                     w_newErr    = w_chkCode;
                     w_nextState = s_last ? S_DONE : S_DRAIN;
                  end else begin
                     w_doWrite   = 1'b1;
                     w_nextState = S_WRITE;
                  end
               end else if (s_last) begin
                  w_newErr    = 3'b100;
                  w_nextState = S_DONE;
               end
            end
         end
         S_WRITE: w_nextState = r_lastBeat ? S_DONE : S_RECV;
         S_DRAIN: begin
            if (w_accept && s_last)
               w_nextState = S_DONE;
         end
         default: w_nextState = S_IDLE;
      endcase
   end

   // Datapath: byte assembly, write port registers, counters and the sticky first error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_asm       <= '0;
         r_byteCnt   <= '0;
         r_lastBeat  <= 1'b0;
         r_wrEn      <= 1'b0;
         r_wrAddr    <= '0;
         r_wrData    <= '0;
         r_errCode   <= 3'b000;
         r_nodeCount <= '0;
      end else begin
         r_wrEn <= w_doWrite;
         if (w_clear) begin
            r_byteCnt   <= '0;
            r_nodeCount <= '0;
            r_errCode   <= 3'b000;
         end
         if ((r_state == S_RECV) && w_accept) begin
            r_asm      <= w_word[IMG_BITS-9:0];
            r_byteCnt  <= (r_byteCnt == LAST_BYTE) ? 4'd0 : r_byteCnt + 4'd1;
            r_lastBeat <= s_last;
         end
         if (w_doWrite) begin
            r_wrAddr <= w_addr;
            r_wrData <= w_word[NODE_WIDTH-1:0];
         end
         if (r_state == S_WRITE)
            r_nodeCount <= r_nodeCount + 1'b1;
         if ((w_newErr != 3'b000) && (r_errCode == 3'b000))
            r_errCode <= w_newErr;
      end
   end

   assign wr_en      = r_wrEn;
   assign wr_addr    = r_wrAddr;
   assign wr_data    = r_wrData;
   assign err_code   = r_errCode;
   assign error      = (r_errCode != 3'b000);
   assign node_count = r_nodeCount;

endmodule

// File: tb/tb_tree_node_loader.sv
// Directed and randomized bench for tree_node_loader; expectations come from a
// node-level reference model applied to the byte image the bench streams in.
module tb_tree_node_loader;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        s_valid = 1'b0;
   logic [7:0]  s_data = 8'h00;
   logic        s_last = 1'b0;
   logic        s_ready;
   logic        wr_en;
   logic [8:0]  wr_addr;
   logic [94:0] wr_data;
   logic        busy;
   logic        done;
   logic        error;
   logic [2:0]  err_code;
   logic [9:0]  node_count;

   tree_node_loader #(.TREE_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
      .s_last(s_last), .s_ready(s_ready), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .busy(busy), .done(done), .error(error),
      .err_code(err_code), .node_count(node_count)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cycle  = 0;

   logic [7:0]  img[$];
   logic [8:0]  gotAddr[$];
   logic [94:0] gotData[$];
   int          gotCyc[$];
   logic [8:0]  expAddr[$];
   logic [94:0] expData[$];
   int          expErr;
   int          expCount;

   always @(posedge clk) cycle++;

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Every write strobe is logged; a write cycle must never offer s_ready.
   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         gotAddr.push_back(wr_addr);
         gotData.push_back(wr_data);
         gotCyc.push_back(cycle);
         checkOutput("readyInWrite", 128'(s_ready), 128'(0));
      end
   end

   function automatic void addNode(input logic pad, input int id, input int feat, input logic [63:0] thr,
                                   input int left, input int right, input int pred);
      logic [95:0] w;
      w = {pad, 9'(id), 2'(feat), thr, 9'(left), 9'(right), 2'(pred)};
      for (int b = 11; b >= 0; b--) img.push_back(w[b*8 +: 8]);
   endfunction

   // Reference model: walk the image node by node and apply the loader's rules.
   function automatic void runModel();
      logic [95:0] w;
      int cnt, id, left, right;
      cnt = 0;
      expErr = 0;
      expAddr.delete();
      expData.delete();
      for (int k = 0; k < img.size(); k++) begin
         if (cnt == DEPTH) begin expErr = 5; break; end
         if ((k % 12) != 11) begin
            if (k == img.size() - 1) begin expErr = 4; break; end
         end else begin
            w = '0;
            for (int b = 0; b < 12; b++) w = {w[87:0], img[k-11+b]};
            id    = int'(w[94:86]);
            left  = int'(w[19:11]);
            right = int'(w[10:2]);
            if (w[95]) expErr = 3;
            else if (id != cnt) expErr = 1;
            else if ((left == 0) != (right == 0)) expErr = 2;
            else if (left != 0 && (left <= cnt || right <= cnt)) expErr = 2;
            else if (left >= DEPTH || right >= DEPTH) expErr = 2;
            if (expErr != 0) break;
            expAddr.push_back(9'(cnt));
            expData.push_back(w[94:0]);
            cnt++;
         end
      end
      expCount = cnt;
   endfunction

   task automatic pulseStart();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic applyStimulus(input int fromIdx, input int toIdx, input bit gaps);
      int idx = fromIdx;
      int guard = 0;
      while (idx < toIdx && guard < 5000) begin
         @(negedge clk);
         guard++;
         if (gaps && $urandom_range(0, 3) == 0) begin
            s_valid = 1'b0;
            s_last  = 1'b0;
         end else begin
            s_valid = 1'b1;
            s_data  = img[idx];
            s_last  = (idx == img.size() - 1);
            if (s_ready === 1'b1) idx++;
         end
      end
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (idx < toIdx) checkOutput("streamTimeout", 128'(idx), 128'(toIdx));
   endtask

   task automatic waitDone();
      for (int i = 0; i < 40 && done !== 1'b1; i++) @(negedge clk);
   endtask

   task automatic compareLoad(input string tag);
      runModel();
      checkOutput({tag, ".done"}, 128'(done), 128'(1));
      checkOutput({tag, ".busy"}, 128'(busy), 128'(0));
      checkOutput({tag, ".errCode"}, 128'(err_code), 128'(expErr));
      checkOutput({tag, ".error"}, 128'(error), 128'(expErr != 0));
      checkOutput({tag, ".nodeCount"}, 128'(node_count), 128'(expCount));
      checkOutput({tag, ".writes"}, 128'(gotAddr.size()), 128'(expAddr.size()));
      for (int i = 0; i < expAddr.size() && i < gotAddr.size(); i++) begin
         checkOutput($sformatf("%s.addr%0d", tag, i), 128'(gotAddr[i]), 128'(expAddr[i]));
         checkOutput($sformatf("%s.data%0d", tag, i), 128'(gotData[i]), 128'(expData[i]));
      end
   endtask

   task automatic clearLog();
      gotAddr.delete();
      gotData.delete();
      gotCyc.delete();
   endtask

   task automatic runLoad(input string tag, input bit gaps);
      clearLog();
      pulseStart();
      applyStimulus(0, img.size(), gaps);
      waitDone();
      compareLoad(tag);
   endtask

   initial begin
      int n, id, left, right, kind, drop;
      logic pad;

      #12;
      checkOutput("rst.wrEn", 128'(wr_en), 128'(0));
      checkOutput("rst.wrData", 128'(wr_data), 128'(0));
      checkOutput("rst.ready", 128'(s_ready), 128'(0));
      checkOutput("rst.busy", 128'(busy), 128'(0));
      checkOutput("rst.done", 128'(done), 128'(0));
      checkOutput("rst.errCode", 128'(err_code), 128'(0));
      checkOutput("rst.nodeCount", 128'(node_count), 128'(0));
      @(negedge clk) rst_n = 1'b1;

      img.delete();
      addNode(0, 0, 0, 64'h0, 0, 0, 1);
      runLoad("leaf", 1);
      checkOutput("leaf.pred", 128'(gotData.size() > 0 ? gotData[0][1:0] : 2'bxx), 128'(2'b01));

      img.delete();
      addNode(0, 0, 2, 64'h100, 1, 2, 0);
      addNode(0, 1, 1, 64'h55, 0, 0, 2);
      addNode(0, 2, 3, 64'h77, 0, 0, 3);
      runLoad("three", 0);
      for (int i = 1; i < gotCyc.size(); i++)
         checkOutput($sformatf("three.spacing%0d", i), 128'(gotCyc[i] - gotCyc[i-1]), 128'(13));

      img.delete();
      addNode(0, 0, 0, 64'h1, 1, 2, 0);
      addNode(0, 1, 0, 64'h2, 2, 3, 0);
      addNode(0, 2, 0, 64'h3, 0, 0, 1);
      addNode(0, 3, 0, 64'h4, 0, 0, 2);
      addNode(0, 4, 0, 64'h5, 0, 0, 3);
      runLoad("ovf", 1);
      checkOutput("ovf.code", 128'(err_code), 128'(3'b101));

      img.delete();
      addNode(0, 5, 0, 64'h0, 0, 0, 0);
      addNode(0, 1, 0, 64'h0, 0, 0, 0);
      addNode(0, 2, 0, 64'h0, 0, 0, 0);
      clearLog();
      pulseStart();
      applyStimulus(0, 14, 0);
      checkOutput("badId.drainReady", 128'(s_ready), 128'(1));
      applyStimulus(14, img.size(), 0);
      waitDone();
      compareLoad("badId");
      checkOutput("badId.code", 128'(err_code), 128'(3'b001));

      img.delete();
      addNode(0, 0, 0, 64'h9, 1, 2, 0);
      addNode(0, 1, 0, 64'h9, 1, 3, 0);
      runLoad("backRef", 1);
      checkOutput("backRef.code", 128'(err_code), 128'(3'b010));

      img.delete();
      addNode(0, 0, 0, 64'h9, 1, 2, 0);
      addNode(0, 1, 0, 64'h9, 0, 4, 0);
      runLoad("halfLeaf", 1);
      checkOutput("halfLeaf.code", 128'(err_code), 128'(3'b010));

      img.delete();
      addNode(0, 0, 0, 64'h9, 1, 2, 0);
      addNode(0, 1, 0, 64'h9, 0, 0, 1);
      addNode(0, 2, 0, 64'h9, 0, 0, 1);
      for (int i = 0; i < 5; i++) void'(img.pop_back());
      runLoad("trunc", 1);
      checkOutput("trunc.code", 128'(err_code), 128'(3'b100));

      img.delete();
      addNode(1, 0, 0, 64'h0, 0, 0, 1);
      runLoad("pad", 1);
      checkOutput("pad.code", 128'(err_code), 128'(3'b011));

      pulseStart();
      checkOutput("restart.done", 128'(done), 128'(0));
      checkOutput("restart.error", 128'(error), 128'(0));
      checkOutput("restart.nodeCount", 128'(node_count), 128'(0));
      img.delete();
      addNode(0, 0, 0, 64'hABCD, 0, 0, 2);
      clearLog();
      applyStimulus(0, img.size(), 1);
      waitDone();
      compareLoad("restart");

      img.delete();
      addNode(0, 0, 1, 64'h10, 1, 2, 0);
      addNode(0, 1, 0, 64'h20, 0, 0, 1);
      addNode(0, 2, 0, 64'h30, 0, 0, 2);
      clearLog();
      pulseStart();
      applyStimulus(0, 17, 1);
      checkOutput("midStart.before", 128'(node_count), 128'(1));
      pulseStart();
      checkOutput("midStart.after", 128'(node_count), 128'(1));
      checkOutput("midStart.busy", 128'(busy), 128'(1));
      applyStimulus(17, img.size(), 1);
      waitDone();
      compareLoad("midStart");

      for (int t = 0; t < 25; t++) begin
         img.delete();
         n = $urandom_range(1, 6);
         for (int i = 0; i < n; i++) begin
            pad  = ($urandom_range(0, 15) == 0);
            id   = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : i;
            kind = $urandom_range(0, 9);
            left = 0;
            right = 0;
            if (kind >= 5 && kind < 8 && i + 1 < DEPTH) begin
               left  = $urandom_range(i + 1, DEPTH - 1);
               right = $urandom_range(i + 1, DEPTH - 1);
            end else if (kind >= 8) begin
               left  = $urandom_range(0, 7);
               right = $urandom_range(0, 7);
            end
            addNode(pad, id, $urandom_range(0, 3), {$urandom, $urandom}, left, right, $urandom_range(0, 3));
         end
         if ($urandom_range(0, 4) == 0) begin
            drop = $urandom_range(1, 11);
            for (int i = 0; i < drop; i++) void'(img.pop_back());
         end
         runLoad($sformatf("rand%0d", t), 1'($urandom_range(0, 1)));
      end

      img.delete();
      addNode(0, 0, 0, 64'h0, 0, 0, 1);
      clearLog();
      pulseStart();
      applyStimulus(0, 11, 0);
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = img[11];
      s_last  = 1'b1;
      @(posedge clk);
      #2;
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_last  = 1'b0;
      @(negedge clk);
      checkOutput("rstMid.writes", 128'(gotAddr.size()), 128'(0));
      checkOutput("rstMid.wrEn", 128'(wr_en), 128'(0));
      checkOutput("rstMid.wrData", 128'(wr_data), 128'(0));
      checkOutput("rstMid.busy", 128'(busy), 128'(0));
      checkOutput("rstMid.ready", 128'(s_ready), 128'(0));
      checkOutput("rstMid.done", 128'(done), 128'(0));
      checkOutput("rstMid.nodeCount", 128'(node_count), 128'(0));
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rstMid.idle", 128'({busy, done, s_ready, wr_en}), 128'(0));
      checkOutput("rstMid.noLateWrite", 128'(gotAddr.size()), 128'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
